// File: rtl/enc_rr_arbiter.sv
// Round-robin arbiter for 8 requesters: registered one-hot grant plus binary index, held until release.
// Optional grant watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module enc_rr_arbiter #(
  parameter int N       = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [N-1:0]     gnt_reg, gnt_next;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] sel_off, sel_idx;
  logic             owner_release, expire, release_any;

  // Rotate req so that bit 0 is the requester currently holding top priority.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign req_rot[gi] = req[ptr_reg + IDX_W'(gi)];
  end

  always_comb begin
    sel_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) sel_off = IDX_W'(i);
    end
  end

  assign sel_idx       = ptr_reg + sel_off;
  assign owner_release = done | ~req[idx_reg];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wdog_reg;
  logic       timeout_reg;

  // An owner release in the expiry cycle wins, so timeout only fires on a true revoke.
  assign expire = (state_reg == GRANT) && (wdog_reg == 8'(TIMEOUT - 1)) && !owner_release;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wdog_reg    <= (state_reg == GRANT) ? wdog_reg + 8'd1 : 8'd0;
      timeout_reg <= expire;
    end
  end

  assign timeout = timeout_reg;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign release_any = owner_release | expire;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    gnt_next   = gnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next   = {{(N-1){1'b0}}, 1'b1} << sel_idx;
          idx_next   = sel_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_any) begin
          gnt_next   = '0;
          idx_next   = '0;
          ptr_next   = idx_reg + IDX_W'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      gnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      gnt_reg   <= gnt_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = idx_reg;
  assign gnt_valid = |gnt_reg;

endmodule
